// File: rtl/adder_operand_sequencer.sv
// Operand entry and result capture for the 4-bit ripple adder: a debounced Enter
// loads P then Q, a one-cycle add state latches the adder's sum, and the result is shown.
module adder_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Enter,
  input  logic             Clear,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH:0]   SumIn,
  output logic [WIDTH:0]   SumOut,
  output logic             Carry,
  output logic             Done,
  output logic [1:0]       State
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_P    = 2'b00,
    S_Q    = 2'b01,
    S_ADD  = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             pulse_q, pulse_d;

  // A low sample restarts the count and re-arms; the pulse fires once when the count first tops out.
  always_comb begin
    cnt_d   = '0;
    armed_d = 1'b1;
    pulse_d = 1'b0;
    if (sync2_q) begin
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      pulse_d = armed_q && (cnt_d == CNT_MAX);
      armed_d = armed_q && !pulse_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= Enter;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = done_q;
    if (Clear) begin
      state_d = S_P;
      p_d     = '0;
      q_d     = '0;
      sum_d   = '0;
      carry_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_P: if (pulse_q) begin
          p_d     = Data;
          state_d = S_Q;
        end
        S_Q: if (pulse_q) begin
          q_d     = Data;
          state_d = S_ADD;
        end
        // P and Q have been stable a full cycle here, so SumIn has settled; any pulse is dropped.
        S_ADD: begin
          sum_d   = SumIn;
          carry_d = SumIn[WIDTH];
          done_d  = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: if (pulse_q) begin
          p_d     = Data;
          done_d  = 1'b0;
          state_d = S_Q;
        end
        default: state_d = S_P;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_P;
      p_q     <= '0;
      q_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign P      = p_q;
  assign Q      = q_q;
  assign SumOut = sum_q;
  assign Carry  = carry_q;
  assign Done   = done_q;
  assign State  = state_q;

endmodule
